// File: rtl/icache_ram_responder.sv
// Memory-side responder for the icache burst-read port: walks a burst over a
// single-port synchronous RAM with configurable first-beat and inter-beat latency.
module icache_ram_responder #(
  parameter int unsigned FIRST_LAT = 2,
  parameter int unsigned BEAT_GAP  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_raddr_icache_i,
  input  logic        ram_raddr_valid_icache_i,
  input  logic [7:0]  ram_rmask_icache_i,
  input  logic [3:0]  ram_rsize_icache_i,
  input  logic [7:0]  ram_rlen_icache_i,
  output logic        ram_rdata_ready_icache_o,
  output logic [63:0] ram_rdata_icache_o,
  output logic [31:0] mem_raddr_o,
  output logic        mem_ren_o,
  input  logic [63:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ISSUE, S_CAPTURE, S_BEAT, S_DONE
  } state_t;

  localparam logic [7:0] LP_FIRST_LAT = 8'(FIRST_LAT);
  localparam logic [7:0] LP_BEAT_GAP  = 8'(BEAT_GAP);

  state_t      r_state, w_state_next;
  logic [31:0] r_base, w_base_next;
  logic [7:0]  r_mask, w_mask_next;
  logic [7:0]  r_len, w_len_next;
  logic [1:0]  r_shift, w_shift_next;  // log2 of the beat stride
  logic [7:0]  r_beat_cnt, w_beat_cnt_next;
  logic [7:0]  r_wait_cnt, w_wait_cnt_next;

  logic        r_ready, r_ren;
  logic [63:0] r_data;
  logic [31:0] r_addr;

  logic [31:0] w_addr_sum;
  logic [63:0] w_masked;
  logic        w_ren_next, w_ready_next;
  logic [1:0]  w_size_shift;

  always_comb begin
    case (ram_rsize_icache_i)
      4'd1:    w_size_shift = 2'd0;
      4'd2:    w_size_shift = 2'd1;
      4'd4:    w_size_shift = 2'd2;
      default: w_size_shift = 2'd3;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign w_masked[gi*8 +: 8] = r_mask[gi] ? mem_rdata_i[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    w_state_next    = r_state;
    w_base_next     = r_base;
    w_mask_next     = r_mask;
    w_len_next      = r_len;
    w_shift_next    = r_shift;
    w_beat_cnt_next = r_beat_cnt;
    w_wait_cnt_next = r_wait_cnt;

    case (r_state)
      S_IDLE: begin
        if (ram_raddr_valid_icache_i) begin
          w_base_next     = ram_raddr_icache_i;
          w_mask_next     = ram_rmask_icache_i;
          w_len_next      = ram_rlen_icache_i;
          w_shift_next    = w_size_shift;
          w_beat_cnt_next = 8'd0;
          w_wait_cnt_next = LP_FIRST_LAT;
          w_state_next    = (LP_FIRST_LAT != 8'd0) ? S_WAIT : S_ISSUE;
        end
      end
      S_WAIT: begin
        w_wait_cnt_next = r_wait_cnt - 8'd1;
        if (r_wait_cnt <= 8'd1) w_state_next = S_ISSUE;
      end
      S_ISSUE:   w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_BEAT;
      S_BEAT: begin
        if (r_beat_cnt == r_len) begin
          w_state_next = S_DONE;
        end else begin
          w_beat_cnt_next = r_beat_cnt + 8'd1;
          w_wait_cnt_next = LP_BEAT_GAP;
          w_state_next    = (LP_BEAT_GAP != 8'd0) ? S_WAIT : S_ISSUE;
        end
      end
      S_DONE: begin
        if (!ram_raddr_valid_icache_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Initiator dropping valid mid-burst abandons it; outputs follow the next state
    if (!ram_raddr_valid_icache_i &&
        (r_state inside {S_WAIT, S_ISSUE, S_CAPTURE, S_BEAT})) begin
      w_state_next = S_IDLE;
    end
  end

  assign w_addr_sum   = w_base_next + (32'(w_beat_cnt_next) << w_shift_next);
  assign w_ren_next   = (w_state_next == S_ISSUE);
  assign w_ready_next = (r_state == S_CAPTURE) && (w_state_next == S_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_mask     <= '0;
      r_len      <= '0;
      r_shift    <= '0;
      r_beat_cnt <= '0;
      r_wait_cnt <= '0;
      r_ready    <= 1'b0;
      r_ren      <= 1'b0;
      r_data     <= '0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_base     <= w_base_next;
      r_mask     <= w_mask_next;
      r_len      <= w_len_next;
      r_shift    <= w_shift_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_ready    <= w_ready_next;
      r_ren      <= w_ren_next;
      if (w_ren_next)   r_addr <= {w_addr_sum[31:3], 3'b000};
      if (w_ready_next) r_data <= w_masked;
    end
  end

  assign ram_rdata_ready_icache_o = r_ready;
  assign ram_rdata_icache_o       = r_data;
  assign mem_raddr_o              = r_addr;
  assign mem_ren_o                = r_ren;

endmodule

// File: tb/tb_icache_ram_responder.sv
// Bench for icache_ram_responder: two instances (default latency, and zero
// first latency with a beat gap of 2) checked against a beat-schedule model.
module tb_icache_ram_responder;

  localparam int FL0 = 2, BG0 = 0;
  localparam int FL1 = 0, BG1 = 2;

  logic        clk;
  logic        rst_n     [2];
  logic [31:0] raddr     [2];
  logic        rvalid    [2];
  logic [7:0]  rmask     [2];
  logic [3:0]  rsize     [2];
  logic [7:0]  rlen      [2];
  logic        rdy       [2];
  logic [63:0] rdata     [2];
  logic [31:0] mem_raddr [2];
  logic        mem_ren   [2];
  logic [63:0] mem_rdata [2];

  int n_vec = 0;
  int n_err = 0;

  icache_ram_responder #(.FIRST_LAT(FL0), .BEAT_GAP(BG0)) u_dut0 (
    .clk(clk), .rst(rst_n[0]),
    .ram_raddr_icache_i(raddr[0]), .ram_raddr_valid_icache_i(rvalid[0]),
    .ram_rmask_icache_i(rmask[0]), .ram_rsize_icache_i(rsize[0]),
    .ram_rlen_icache_i(rlen[0]), .ram_rdata_ready_icache_o(rdy[0]),
    .ram_rdata_icache_o(rdata[0]), .mem_raddr_o(mem_raddr[0]),
    .mem_ren_o(mem_ren[0]), .mem_rdata_i(mem_rdata[0])
  );

  icache_ram_responder #(.FIRST_LAT(FL1), .BEAT_GAP(BG1)) u_dut1 (
    .clk(clk), .rst(rst_n[1]),
    .ram_raddr_icache_i(raddr[1]), .ram_raddr_valid_icache_i(rvalid[1]),
    .ram_rmask_icache_i(rmask[1]), .ram_rsize_icache_i(rsize[1]),
    .ram_rlen_icache_i(rlen[1]), .ram_rdata_ready_icache_o(rdy[1]),
    .ram_rdata_icache_o(rdata[1]), .mem_raddr_o(mem_raddr[1]),
    .mem_ren_o(mem_ren[1]), .mem_rdata_i(mem_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ram_word(input logic [31:0] a);
    if (a == 32'h0000_0200) return 64'h1122_3344_5566_7788;
    return {a ^ 32'hDEAD_BEEF, a * 32'h9E37_79B1 + 32'd1};
  endfunction

  function automatic logic [63:0] apply_mask(input logic [63:0] w, input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  // Synchronous backing RAM: data valid the cycle after the read strobe
  always @(posedge clk) if (mem_ren[0]) mem_rdata[0] <= ram_word(mem_raddr[0]);
  always @(posedge clk) if (mem_ren[1]) mem_rdata[1] <= ram_word(mem_raddr[1]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one burst on instance d; valid drops at cycle abort_j (<0: never).
  // Expected beats: ready at 3+FL+k*(3+GAP), read strobe two cycles earlier.
  task automatic run_burst(input int d, input logic [31:0] base, input logic [7:0] mask,
                           input logic [3:0] size, input logic [7:0] len, input int abort_j,
                           output int first_rdy, output logic [31:0] last_addr,
                           output logic [63:0] first_data);
    int fl, per, stride, last_j, stop_j, kr, kn;
    logic exp_rdy, exp_ren;
    logic [31:0] a_r, a_n;
    fl     = (d == 0) ? FL0 : FL1;
    per    = 3 + ((d == 0) ? BG0 : BG1);
    stride = (size == 4'd1) ? 1 : (size == 4'd2) ? 2 : (size == 4'd4) ? 4 : 8;
    last_j = 3 + fl + int'(len) * per;
    stop_j = last_j + 3;
    if (abort_j >= 0 && abort_j + 2 < stop_j) stop_j = abort_j + 2;
    first_rdy  = -1;
    last_addr  = 32'hDEAD_DEAD;
    first_data = '0;
    for (int j = 0; j <= stop_j; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin
        raddr[d] = base; rmask[d] = mask; rsize[d] = size; rlen[d] = len;
      end else begin
        raddr[d] = $urandom; rmask[d] = 8'($urandom);
        rsize[d] = 4'($urandom); rlen[d] = 8'($urandom);
      end
      rvalid[d] = (abort_j < 0 || j < abort_j);
      @(negedge clk);
      exp_rdy = 1'b0; exp_ren = 1'b0; kr = 0; kn = 0;
      if (abort_j < 0 || j <= abort_j) begin
        if (j >= 3 + fl && (j - 3 - fl) % per == 0 && (j - 3 - fl) / per <= int'(len)) begin
          exp_rdy = 1'b1; kr = (j - 3 - fl) / per;
        end
        if (j >= 1 + fl && (j - 1 - fl) % per == 0 && (j - 1 - fl) / per <= int'(len)) begin
          exp_ren = 1'b1; kn = (j - 1 - fl) / per;
        end
      end
      a_r = base + 32'(kr * stride); a_r[2:0] = 3'b000;
      a_n = base + 32'(kn * stride); a_n[2:0] = 3'b000;
      chk($sformatf("ready d%0d j%0d", d, j), 64'(rdy[d]), 64'(exp_rdy));
      chk($sformatf("ren d%0d j%0d", d, j), 64'(mem_ren[d]), 64'(exp_ren));
      if (exp_ren) chk($sformatf("addr d%0d j%0d", d, j), 64'(mem_raddr[d]), 64'(a_n));
      if (exp_rdy) chk($sformatf("data d%0d j%0d", d, j), rdata[d],
                       apply_mask(ram_word(a_r), mask));
      if (rdy[d] && first_rdy < 0) begin first_rdy = j; first_data = rdata[d]; end
      if (mem_ren[d]) last_addr = mem_raddr[d];
    end
    @(posedge clk); #1;
    rvalid[d] = 1'b0;
    $display("burst d%0d base=%h mask=%h size=%0d len=%0d abort=%0d first_rdy=%0d",
             d, base, mask, size, len, abort_j, first_rdy);
  endtask

  typedef struct {
    int          inst;
    logic [31:0] base;
    logic [7:0]  mask;
    logic [3:0]  size;
    logic [7:0]  len;
    int          abort_j;
    int          exp_first;
    logic [31:0] exp_last;   // DEAD_DEAD: no RAM read issued
    logic        chk_data;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int fr, ab, lj;
    logic [31:0] la;
    logic [63:0] fd;
    logic [7:0]  ln;

    tbl[0]  = '{0, 32'h8000_0010, 8'hFF, 4'd8, 8'd1,   -1, 5,  32'h8000_0018, 1'b0, 64'h0};
    tbl[1]  = '{1, 32'h0000_1000, 8'hFF, 4'd8, 8'd3,   -1, 3,  32'h0000_1018, 1'b0, 64'h0};
    tbl[2]  = '{0, 32'h0000_0200, 8'h0F, 4'd8, 8'd0,   -1, 5,  32'h0000_0200, 1'b1,
                64'h0000_0000_5566_7788};
    tbl[3]  = '{0, 32'h0000_0100, 8'hFF, 4'd4, 8'd3,   -1, 5,  32'h0000_0108, 1'b0, 64'h0};
    tbl[4]  = '{1, 32'h0000_0100, 8'hFF, 4'd5, 8'd3,   -1, 3,  32'h0000_0118, 1'b0, 64'h0};
    tbl[5]  = '{0, 32'h0000_0100, 8'hFF, 4'd8, 8'd3,   -1, 5,  32'h0000_0118, 1'b0, 64'h0};
    tbl[6]  = '{0, 32'hFFFF_FFF8, 8'hFF, 4'd8, 8'd1,   -1, 5,  32'h0000_0000, 1'b0, 64'h0};
    tbl[7]  = '{0, 32'h0000_0040, 8'hFF, 4'd8, 8'd0,    2, -1, 32'hDEAD_DEAD, 1'b0, 64'h0};
    tbl[8]  = '{0, 32'h0000_0048, 8'hFF, 4'd8, 8'd0,   -1, 5,  32'h0000_0048, 1'b0, 64'h0};
    tbl[9]  = '{1, 32'h0000_0003, 8'hA5, 4'd1, 8'd255, -1, 3,  32'h0000_0100, 1'b0, 64'h0};
    tbl[10] = '{1, 32'h0000_0006, 8'hFF, 4'd2, 8'd4,   -1, 3,  32'h0000_0008, 1'b0, 64'h0};
    tbl[11] = '{1, 32'h0000_0500, 8'hFF, 4'd8, 8'd2,    3, 3,  32'h0000_0500, 1'b0, 64'h0};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; rvalid[d] = 1'b0; raddr[d] = '0;
      rmask[d] = '0; rsize[d] = '0; rlen[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset ready d%0d", d), 64'(rdy[d]), 64'h0);
      chk($sformatf("reset ren d%0d", d), 64'(mem_ren[d]), 64'h0);
      chk($sformatf("reset addr d%0d", d), 64'(mem_raddr[d]), 64'h0);
      chk($sformatf("reset data d%0d", d), rdata[d], 64'h0);
    end
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      run_burst(tbl[i].inst, tbl[i].base, tbl[i].mask, tbl[i].size, tbl[i].len,
                tbl[i].abort_j, fr, la, fd);
      chk($sformatf("tbl%0d first_ready", i), 64'(fr), 64'(tbl[i].exp_first));
      chk($sformatf("tbl%0d last_addr", i), 64'(la), 64'(tbl[i].exp_last));
      if (tbl[i].chk_data) chk($sformatf("tbl%0d data", i), fd, tbl[i].exp_data);
    end

    for (int i = 0; i < 40; i++) begin
      int d;
      d  = int'($urandom_range(0, 1));
      ln = 8'($urandom_range(0, 6));
      lj = 3 + ((d == 0) ? FL0 : FL1) + int'(ln) * (3 + ((d == 0) ? BG0 : BG1));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lj + 2)) : -1;
      run_burst(d, $urandom, 8'($urandom), 4'($urandom_range(0, 15)), ln, ab, fr, la, fd);
    end

    // Asynchronous reset mid-ISSUE, mid-CAPTURE and mid-BEAT on the default instance
    for (int off = 3; off <= 5; off++) begin
      @(posedge clk); #1;
      raddr[0] = 32'h0000_0208; rmask[0] = 8'hFF; rsize[0] = 4'd8; rlen[0] = 8'd2;
      rvalid[0] = 1'b1;
      repeat (off) @(posedge clk);
      @(negedge clk); #1;
      rst_n[0] = 1'b0;
      #1;
      chk($sformatf("arst%0d ready", off), 64'(rdy[0]), 64'h0);
      chk($sformatf("arst%0d ren", off), 64'(mem_ren[0]), 64'h0);
      chk($sformatf("arst%0d addr", off), 64'(mem_raddr[0]), 64'h0);
      chk($sformatf("arst%0d data", off), rdata[0], 64'h0);
      rvalid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n[0] = 1'b1;
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        chk($sformatf("arst%0d post ready j%0d", off, j), 64'(rdy[0]), 64'h0);
        chk($sformatf("arst%0d post ren j%0d", off, j), 64'(mem_ren[0]), 64'h0);
      end
      $display("async reset at offset %0d done", off);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/icache_ram_responder.md
# icache_ram_responder

Memory-side responder for the icache burst-read port. Accepts a burst read request (base address, mask, size, length) from the icache miss engine, fetches each beat from a single-port synchronous backing RAM, and returns one 64-bit beat per `valid & ready` handshake. It sits between the icache's cache-to-mem port and the simulation RAM or AXI bridge. Configurable latency models slow memory for pipeline stall testing.

## Interface
- `FIRST_LAT`, 2: idle cycles inserted between request accept and the first RAM read (0–255).
- `BEAT_GAP`, 0: idle cycles inserted between a beat handshake and the next RAM read (0–255).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock domain only.
- `ram_raddr_icache_i`  in  32  burst base address; sampled only on accept.
- `ram_raddr_valid_icache_i`  in  1  request valid; initiator holds it high for the whole burst.
- `ram_rmask_icache_i`  in  8  byte mask applied to every beat; sampled on accept.
- `ram_rsize_icache_i`  in  4  bytes per beat: 1, 2, 4 or 8. Any other value is treated as 8.
- `ram_rlen_icache_i`  in  8  beats minus one (the initiator sends 1 for 2 beats).
- `ram_rdata_ready_icache_o`  out  1  beat valid; high for exactly one cycle per beat.
- `ram_rdata_icache_o`  out  64  beat data; bytes with a mask bit of 0 read as 0.
- `mem_raddr_o`  out  32  backing RAM address, 8-byte aligned (`[2:0]=0`).
- `mem_ren_o`  out  1  backing RAM read strobe.
- `mem_rdata_i`  in  64  backing RAM data; valid the cycle after `mem_ren_o`.

## Operation
- All outputs are registered. Reset values are 0: `ram_rdata_ready_icache_o`, `ram_rdata_icache_o`, `mem_raddr_o`, `mem_ren_o`. Reset also clears state to IDLE and all counters to 0.
- Latched fields: `base`, `mask`, `len`, `stride`. A `beat_cnt` register (8b) counts beats; a `wait_cnt` register (8b) counts delay cycles.
- IDLE:
  - If valid=1, accept: latch the fields, set `beat_cnt`=0, load `wait_cnt`=FIRST_LAT.
  - Next state is WAIT if FIRST_LAT>0, else ISSUE.
- WAIT: decrement `wait_cnt`. When it reaches 1, the next state is ISSUE.
- ISSUE:
  - `mem_ren_o`=1 for one cycle.
  - `mem_raddr_o` = (`base` + `beat_cnt`*`stride`) with bits [2:0] cleared. The sum is 32-bit and wraps mod 2^32.
  - Next state: CAPTURE.
- CAPTURE: register `mem_rdata_i` masked bytewise by `mask` into `ram_rdata_icache_o`. Set ready=1. Next state: BEAT.
- BEAT:
  - Ready is high during this cycle; the initiator treats this as the handshake. Ready clears at the end of the cycle.
  - If `beat_cnt`==`len`, next state is DONE.
  - Otherwise increment `beat_cnt`, load `wait_cnt`=BEAT_GAP, and go to WAIT, or to ISSUE if BEAT_GAP=0.
- DONE: stay until valid=0, then go to IDLE. A new request cannot be accepted in the same cycle valid drops.
- `ram_rdata_icache_o` holds its last value outside BEAT. Consumers qualify it with ready.
- Data is the full aligned 64-bit RAM word; sub-8-byte sizes are not lane-shifted.

## Timing
- Accept at cycle T (IDLE, valid=1).
  - First ISSUE at T+1+FIRST_LAT.
  - First ready at T+3+FIRST_LAT.
- Beat k ready at cycle t → beat k+1 ready at t+3+BEAT_GAP.
- Burst length is `len`+1 beats. `len`=255 gives 256 beats; `beat_cnt` never overflows.
- Abort: valid=0 in any state other than IDLE or DONE returns to IDLE next cycle. No further ready is issued. A ready already registered for the current cycle still appears.
- Fields sampled at accept are stable; input changes mid-burst are ignored.
- Async reset mid-burst: ready and `mem_ren_o` drop to 0 immediately, without waiting for a clock edge. The burst is not resumed after reset releases.
- Every `mem_ren_o` pulse produces exactly one ready, except when the burst is aborted.

## Test plan
- Default params, base 0x8000_0010, rlen=1, rsize=8, mask=0xFF, RAM[0x10]=A, RAM[0x18]=B → ready at T+5 with data A, then at T+8 with data B. Then DONE until valid drops.
- FIRST_LAT=0, BEAT_GAP=2, rlen=3 → ready at T+3, T+8, T+13, T+18. `mem_raddr_o` = base, +8, +16, +24.
- mask=0x0F, RAM word 0x1122_3344_5566_7788 → data 0x0000_0000_5566_7788.
- rsize=4, rlen=3, base 0x100 → `mem_raddr_o` = 0x100, 0x100, 0x108, 0x108. rsize=5 behaves exactly like rsize=8.
- base 0xFFFF_FFF8, rlen=1 → second `mem_raddr_o`=0x0000_0000.
- Drop valid during WAIT of beat 0 → no ready, back in IDLE next cycle, and the next request is accepted normally. Separately, assert `rst`=0 mid-CAPTURE → all outputs read 0 before the next clock edge.
